// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// a contested round goes to the port that was not granted last time.
module rr_picker
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic               winner,
    output logic               valid
);

    // Winner selection from the request vector and the last-granted port
    always_comb begin
        valid  = |req;
        winner = 1'b0;
        if (req[0] && req[1]) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-ported synchronous memory.
// One access is in flight at a time; read data is captured one cycle after
// the read strobe and returned to the port that issued the read.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out
);

    state_t              r_state;
    logic                r_last;
    logic                r_port;
    logic                r_busy;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_rvalid;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_address;
    logic [DATA_W-1:0]   r_data_in;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_winner;
    logic                w_valid;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    rr_picker u_picker (
        .req    ({req1, req0}),
        .last   (r_last),
        .winner (w_winner),
        .valid  (w_valid)
    );

    // Command fields of the winning port
    assign w_sel_we    = w_winner ? we1    : we0;
    assign w_sel_addr  = w_winner ? addr1  : addr0;
    assign w_sel_wdata = w_winner ? wdata1 : wdata0;

    // Sequencer: accept in IDLE, strobe for one cycle in ISSUE, capture read data in RDWAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_port      <= 1'b0;
            r_busy      <= 1'b0;
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_address   <= '0;
            r_data_in   <= '0;
            r_rdata     <= '0;
        end else begin
            // Pulses and strobes default low; address/data_in/rdata hold
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_mem_read        <= ~w_sel_we;
                        r_mem_write       <= w_sel_we;
                        r_address         <= w_sel_addr;
                        r_data_in         <= w_sel_wdata;
                        r_gnt[w_winner]   <= 1'b1;
                        r_last            <= w_winner;
                        r_port            <= w_winner;
                        r_busy            <= 1'b1;
                        r_state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The memory performs the access at this closing edge
                    if (r_mem_read) begin
                        r_state <= RDWAIT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                RDWAIT: begin
                    r_rdata          <= data_out;
                    r_rvalid[r_port] <= 1'b1;
                    r_busy           <= 1'b0;
                    r_state          <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt0     = r_gnt[0];
    assign gnt1     = r_gnt[1];
    assign rvalid0  = r_rvalid[0];
    assign rvalid1  = r_rvalid[1];
    assign rdata    = r_rdata;
    assign busy     = r_busy;
    assign MemRead  = r_mem_read;
    assign MemWrite = r_mem_write;
    assign address  = r_address;
    assign data_in  = r_data_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table of single accesses, hand-written
// multi-cycle corner cases, then random traffic against a transaction model.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_clr;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, busy, MemRead, MemWrite;
    logic [7:0] rdata, address, data_in, data_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata    (rdata),
        .busy     (busy),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out)
    );

    // 256x8 synchronous memory: write at the edge, read data registered
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            data_out <= 8'h00;
        end else begin
            if (MemWrite) mem[address] <= data_in;
            if (MemRead)  data_out <= mem[address];
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Read and write strobes must never overlap
    always @(negedge clk) begin
        if (rst === 1'b0) chk1("rw_exclusive", MemRead & MemWrite, 1'b0);
    end

    task automatic drive(input bit p, input bit r, input bit we, input logic [7:0] a, input logic [7:0] d);
        if (p) begin req1 = r; we1 = we; addr1 = a; wdata1 = d; end
        else   begin req0 = r; we0 = we; addr0 = a; wdata0 = d; end
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_clr = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h33; wdata0 = 8'h44;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h55; wdata1 = 8'h66;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_gnt0", gnt0, 1'b0);
        chk1("rst_gnt1", gnt1, 1'b0);
        chk1("rst_rvalid0", rvalid0, 1'b0);
        chk1("rst_rvalid1", rvalid1, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_memread", MemRead, 1'b0);
        chk1("rst_memwrite", MemWrite, 1'b0);
        chk8("rst_address", address, 8'h00);
        chk8("rst_data_in", data_in, 8'h00);
        chk8("rst_rdata", rdata, 8'h00);
        rst = 1'b0; mem_clr = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
    endtask

    // One isolated access from an idle arbiter, checked cycle by cycle
    task automatic run_txn(input bit p, input bit we, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] exp_rd);
        drive(p, 1'b1, we, a, d);
        @(posedge clk); #1;
        chk1("gnt_own", p ? gnt1 : gnt0, 1'b1);
        chk1("gnt_other", p ? gnt0 : gnt1, 1'b0);
        chk1("issue_memwrite", MemWrite, we);
        chk1("issue_memread", MemRead, !we);
        chk8("issue_address", address, a);
        chk8("issue_data_in", data_in, d);
        chk1("issue_busy", busy, 1'b1);
        drive(p, 1'b0, we, a, d);
        @(posedge clk); #1;
        chk1("post_memwrite", MemWrite, 1'b0);
        chk1("post_memread", MemRead, 1'b0);
        chk1("post_gnt", gnt0 | gnt1, 1'b0);
        if (we) begin
            chk1("write_busy_done", busy, 1'b0);
        end else begin
            chk1("rdwait_busy", busy, 1'b1);
            chk1("rdwait_rvalid", rvalid0 | rvalid1, 1'b0);
            @(posedge clk); #1;
            chk1("rvalid_own", p ? rvalid1 : rvalid0, 1'b1);
            chk1("rvalid_other", p ? rvalid0 : rvalid1, 1'b0);
            chk8("rdata", rdata, exp_rd);
            chk1("read_busy_done", busy, 1'b0);
        end
        $display("txn port=%0d we=%0d addr=%02h wdata=%02h rdata=%02h", p, we, a, d, rdata);
    endtask

    typedef struct {
        bit         port;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    typedef struct {
        bit         v;
        bit         we;
        logic [7:0] a;
        logic [7:0] d;
    } txn_t;

    vec_t       tbl [7];
    txn_t       pend [2];
    logic [7:0] ref_mem [256];
    int         order [4];

    initial begin
        int n_gnt, rv1_cnt, m_free, act_start, k;
        bit act_v, act_port, act_we, m_last, w;
        logic [7:0] act_a, act_d, act_rd, e_addr, e_din, e_rdata;

        tbl[0] = '{1'b1, 1'b1, 8'h10, 8'h5A, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 8'h10, 8'hC3, 8'h5A};
        tbl[2] = '{1'b0, 1'b1, 8'hFF, 8'hA5, 8'h00};
        tbl[3] = '{1'b1, 1'b0, 8'hFF, 8'h11, 8'hA5};
        tbl[4] = '{1'b1, 1'b1, 8'h00, 8'h3C, 8'h00};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 8'h22, 8'h3C};
        tbl[6] = '{1'b1, 1'b0, 8'h10, 8'h99, 8'h5A};

        do_reset();

        for (int i = 0; i < 7; i++)
            run_txn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata);

        // req0 held across its grant with a new address: two distinct writes
        drive(1'b0, 1'b1, 1'b1, 8'h01, 8'h11);
        @(posedge clk); #1;
        chk1("hold_gnt_a", gnt0, 1'b1);
        chk8("hold_addr_a", address, 8'h01);
        drive(1'b0, 1'b1, 1'b1, 8'h02, 8'h22);
        @(posedge clk); #1;
        chk1("hold_gap", gnt0, 1'b0);
        @(posedge clk); #1;
        chk1("hold_gnt_b", gnt0, 1'b1);
        chk8("hold_addr_b", address, 8'h02);
        chk8("hold_data_b", data_in, 8'h22);
        drive(1'b0, 1'b0, 1'b1, 8'h02, 8'h22);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk1("hold_no_third", gnt0, 1'b0);
        chk8("hold_mem_a", mem[8'h01], 8'h11);
        chk8("hold_mem_b", mem[8'h02], 8'h22);
        $display("txn port=0 held-request writes 01=11 02=22");

        // Reset during RDWAIT abandons the read
        drive(1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
        @(posedge clk); #1;
        chk1("rdw_gnt", gnt1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk1("rdw_rvalid0", rvalid0, 1'b0);
        chk1("rdw_rvalid1", rvalid1, 1'b0);
        chk8("rdw_rdata", rdata, 8'h00);
        chk1("rdw_busy", busy, 1'b0);
        @(posedge clk); #1;
        chk1("rdw_rvalid_late", rvalid0 | rvalid1, 1'b0);
        $display("txn port=1 read 10 abandoned by reset");
        run_txn(1'b1, 1'b0, 8'h10, 8'h00, 8'h5A);

        // Reset during ISSUE: the write still reaches memory
        drive(1'b0, 1'b1, 1'b1, 8'h40, 8'h77);
        @(posedge clk); #1;
        chk1("rsi_gnt", gnt0, 1'b1);
        chk1("rsi_memwrite", MemWrite, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 8'h40, 8'h77);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk1("rsi_busy", busy, 1'b0);
        chk1("rsi_strobe", MemWrite | MemRead, 1'b0);
        chk8("rsi_mem", mem[8'h40], 8'h77);
        $display("txn port=0 write 40=77 with reset in ISSUE");
        run_txn(1'b0, 1'b0, 8'h40, 8'h00, 8'h77);

        // Both ports requesting continuously from reset: grants alternate 0,1,0,1
        do_reset();
        for (int i = 0; i < 4; i++) order[i] = 9;
        drive(1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
        drive(1'b1, 1'b1, 1'b1, 8'h21, 8'h33);
        n_gnt = 0; rv1_cnt = 0;
        for (int c = 0; c < 40 && n_gnt < 4; c++) begin
            @(posedge clk); #1;
            if (rvalid1) rv1_cnt++;
            if (gnt0 && n_gnt < 4) begin order[n_gnt] = 0; n_gnt++; end
            else if (gnt1 && n_gnt < 4) begin order[n_gnt] = 1; n_gnt++; end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rvalid1) rv1_cnt++;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (order[i] != (i % 2)) begin
                errors++;
                $display("FAIL rr_order[%0d]: got port %0d expected port %0d", i, order[i], i % 2);
            end
        end
        checks++;
        if (rv1_cnt != 0) begin
            errors++;
            $display("FAIL rr_rvalid1: got %0d pulses expected 0", rv1_cnt);
        end
        chk8("rr_mem21", mem[8'h21], 8'h33);
        $display("txn round-robin grants %0d %0d %0d %0d", order[0], order[1], order[2], order[3]);

        // Random traffic against a transaction-level model
        do_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        pend[0].v = 1'b0; pend[1].v = 1'b0;
        m_last = 1'b1; m_free = 0; act_v = 1'b0; act_start = 0;
        act_port = 1'b0; act_we = 1'b0; act_a = 8'h00; act_d = 8'h00; act_rd = 8'h00;
        e_addr = 8'h00; e_din = 8'h00; e_rdata = 8'h00;
        for (int n = 0; n < 600; n++) begin
            k = act_v ? (n - act_start) : 99;
            if (k == 0) begin e_addr = act_a; e_din = act_d; end
            if (k == 2 && !act_we) e_rdata = act_rd;
            chk1("r_gnt0", gnt0, k == 0 && act_port == 1'b0);
            chk1("r_gnt1", gnt1, k == 0 && act_port == 1'b1);
            chk1("r_memwrite", MemWrite, k == 0 && act_we);
            chk1("r_memread", MemRead, k == 0 && !act_we);
            chk1("r_busy", busy, k == 0 || (k == 1 && !act_we));
            chk1("r_rvalid0", rvalid0, k == 2 && !act_we && act_port == 1'b0);
            chk1("r_rvalid1", rvalid1, k == 2 && !act_we && act_port == 1'b1);
            chk8("r_address", address, e_addr);
            chk8("r_data_in", data_in, e_din);
            chk8("r_rdata", rdata, e_rdata);
            if (k == 0) begin
                pend[act_port].v = 1'b0;
                $display("txn rnd port=%0d we=%0d addr=%02h data=%02h", act_port, act_we, act_a,
                         act_we ? act_d : act_rd);
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p].v && $urandom_range(0, 2) != 0) begin
                    pend[p].v  = 1'b1;
                    pend[p].we = 1'($urandom_range(0, 1));
                    pend[p].a  = 8'($urandom_range(0, 15));
                    pend[p].d  = 8'($urandom_range(0, 255));
                end
                drive(p[0], pend[p].v, pend[p].we, pend[p].a, pend[p].d);
            end
            if (n == m_free) begin
                if (pend[0].v || pend[1].v) begin
                    w = (pend[0].v && pend[1].v) ? !m_last : pend[1].v;
                    m_last    = w;
                    act_v     = 1'b1;
                    act_port  = w;
                    act_we    = pend[w].we;
                    act_a     = pend[w].a;
                    act_d     = pend[w].d;
                    act_start = n + 1;
                    if (act_we) begin
                        ref_mem[act_a] = act_d;
                        m_free = n + 2;
                    end else begin
                        act_rd = ref_mem[act_a];
                        m_free = n + 3;
                    end
                end else begin
                    m_free = n + 1;
                end
            end
            @(posedge clk); #1;
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
